// File: rtl/dot_acc_pkg.sv
// Shared definitions for the dot-product sequencer: default sizes and the
// controller state encoding.
package dot_acc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/dot_unit.sv
// Complete dot-product unit: the sequencer/accumulator wired to the
// sequential multiplier. The start pulse is already active-high.
module dot_unit
  import dot_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic               mult_start;
  logic [2*WIDTH-1:0] mult_p;
  logic               mult_rdy;

  dot_acc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_start (mult_start),
    .mult_p     (mult_p),
    .mult_rdy   (mult_rdy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .cnt        (cnt),
    .ovf        (ovf)
  );

  seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk   (clk),
    .reset (mult_start),
    .a     (mult_a),
    .b     (mult_b),
    .p     (mult_p),
    .rdy   (mult_rdy)
  );

endmodule

// File: rtl/seq_mult.sv
// Signed shift-add multiplier. An active-high reset loads new operands and
// restarts the run; rdy rises once the product is valid and stays high.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               rdy
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_q, neg_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               rdy_q, rdy_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Work on magnitudes; the most negative operand still fits as unsigned.
  always_comb begin
    a_mag    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    p_d      = p_q;
    neg_d    = neg_q;
    step_d   = step_q;
    rdy_d    = rdy_q;
    if (reset) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      prod_d   = '0;
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
      step_d   = '0;
      rdy_d    = 1'b0;
    end else if (!rdy_q) begin
      if (step_q != STEP_W'(WIDTH)) begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + STEP_W'(1);
      end else begin
        p_d   = neg_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;
        rdy_d = 1'b1;
      end
    end
  end

  // NOTE: no reset here on purpose -- every flop is loaded by the start pulse
  // before its value is ever consumed, so a reset net would buy nothing.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    p_q      <= p_d;
    neg_q    <= neg_d;
    step_q   <= step_d;
    rdy_q    <= rdy_d;
  end

  assign p   = p_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/dot_acc.sv
// Operand sequencer and wide accumulator around seq_mult: one multiplier run
// per accepted pair, result presented when the pair tagged last is summed.
module dot_acc
  import dot_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_last,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  output logic               mult_start,
  input  logic [2*WIDTH-1:0] mult_p,
  input  logic               mult_rdy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc,
  output logic [CNT_W-1:0]   cnt,
  output logic               ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  logic               last_q, last_d;
  logic               armed_q, armed_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic signed [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0]        sum;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    last_d   = last_q;
    armed_d  = armed_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    p_ext    = ACC_W'($signed(mult_p));
    sum      = acc_q + p_ext;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mult_a_d = in_a;
          mult_b_d = in_b;
          last_d   = in_last;
          state_d  = S_START;
        end
      end
      S_START: begin
        armed_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // rdy may still be high from the previous run during the first cycle.
        armed_d = 1'b1;
        if (armed_q && mult_rdy) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = sum;
        if ((acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
          ovf_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d  = S_IDLE;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      last_d   = 1'b0;
      armed_d  = 1'b0;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mult_a_q <= '0;
      mult_b_q <= '0;
      last_q   <= 1'b0;
      armed_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      last_q   <= last_d;
      armed_q  <= armed_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign mult_start = (state_q == S_START);
  assign out_valid  = (state_q == S_DONE);
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign acc        = acc_q;
  assign cnt        = cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc: a 24-bit and a 16-bit accumulator share one
// stimulus stream and one behavioural multiplier whose rdy drops a cycle late.
module tb_dot_acc;

  localparam int M_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;

  logic [15:0] mult_p = 16'h7777;
  logic        mult_rdy = 1'b1;

  logic        in_ready, mult_start, out_valid, ovf;
  logic [7:0]  mult_a, mult_b, cnt;
  logic [23:0] acc;

  logic        in_ready16, mult_start16, out_valid16, ovf16;
  logic [7:0]  mult_a16, mult_b16, cnt16;
  logic [15:0] acc16;

  dot_acc #(.WIDTH(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .reset(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_p(mult_p), .mult_rdy(mult_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .cnt(cnt), .ovf(ovf)
  );

  dot_acc #(.WIDTH(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mult_a(mult_a16), .mult_b(mult_b16), .mult_start(mult_start16),
    .mult_p(mult_p), .mult_rdy(mult_rdy),
    .out_valid(out_valid16), .out_ready(out_ready), .acc(acc16), .cnt(cnt16), .ovf(ovf16)
  );

  // Behavioural multiplier: rdy/p stay stale through the first WAIT cycle.
  logic m_pend = 1'b0;
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  always @(posedge clk) begin
    m_pend <= mult_start;
    if (m_pend) begin
      mult_rdy <= 1'b0;
      m_busy   <= 1'b1;
      m_cnt    <= M_LAT;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mult_rdy <= 1'b1;
        mult_p   <= 16'($signed(mult_a) * $signed(mult_b));
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [23:0] acc24;
    logic [15:0] acc16;
    logic [7:0]  cnt;
    logic        ovf24;
    logic        ovf16;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  longint s24 = 0;
  longint s16 = 0;
  bit     o24 = 1'b0;
  bit     o16 = 1'b0;
  int     mcnt = 0;

  function automatic longint wrap(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_reset();
    s24 = 0; s16 = 0; o24 = 1'b0; o16 = 1'b0; mcnt = 0;
  endtask

  task automatic model_add(input int p);
    longint t;
    t = s24 + p;
    if (t >= (longint'(1) << 23) || t < -(longint'(1) << 23)) o24 = 1'b1;
    s24 = wrap(t, 24);
    t = s16 + p;
    if (t >= (longint'(1) << 15) || t < -(longint'(1) << 15)) o16 = 1'b1;
    s16 = wrap(t, 16);
    if (mcnt < 255) mcnt++;
  endtask

  task automatic push_expect();
    exp_t e;
    e.acc24 = 24'(s24);
    e.acc16 = 16'(s16);
    e.cnt   = 8'(mcnt);
    e.ovf24 = o24;
    e.ovf16 = o16;
    sb.push_back(e);
    model_reset();
  endtask

  // Result monitor: compares on every output handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("acc24", 32'(acc), 32'(mon_e.acc24));
        chk("cnt", 32'(cnt), 32'(mon_e.cnt));
        chk("ovf24", 32'(ovf), 32'(mon_e.ovf24));
        chk("valid16", 32'(out_valid16), 32'd1);
        chk("acc16", 32'(acc16), 32'(mon_e.acc16));
        chk("cnt16", 32'(cnt16), 32'(mon_e.cnt));
        chk("ovf16", 32'(ovf16), 32'(mon_e.ovf16));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit last);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_add(a * b);
    if (last) push_expect();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_start"}, 32'(mult_start), 32'd0);
    chk({tag, "_acc"}, 32'(acc), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    chk_idle_zero("rst");
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_acc16", 32'(acc16), 32'd0);
    rst = 1'b1;
    tick();

    // Single term: 3 * -4 = -12
    send(3, -4, 1'b1);
    wait_drain("drain_single");

    // Four terms: 16129 + 16384 - 1 + 0 = 32512
    send(127, 127, 1'b0);
    send(-128, -128, 1'b0);
    send(-1, 1, 1'b0);
    send(0, 55, 1'b1);
    wait_drain("drain_four");

    // 16384 * 2 overflows the 16-bit accumulator only
    send(-128, -128, 1'b0);
    send(-128, -128, 1'b1);
    wait_drain("drain_ovf");

    // Backpressure: result held, nothing accepted or launched
    out_ready = 1'b0;
    send(3, 5, 1'b1);
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_start", 32'(mult_start), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_acc", 32'(acc), 32'd15);
      chk("bp_hold_cnt", 32'(cnt), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_idle_zero("bp_release");
    chk("bp_popped", 32'(sb.size()), 32'd0);

    // Reset during WAIT of (9,9)
    send(9, 9, 1'b1);
    sb.delete();
    repeat (3) tick();
    chk("rst_mid_a", 32'(mult_a), 32'd9);
    rst = 1'b0;
    #1;
    chk_idle_zero("rst_mid");
    chk("rst_mid_mult_a", 32'(mult_a), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    send(5, 6, 1'b1);
    wait_drain("drain_after_rst");

    // Clear during WAIT of (7,7) after a first term of 100
    send(10, 10, 1'b0);
    send(7, 7, 1'b1);
    sb.delete();
    repeat (3) tick();
    chk("clr_pre_acc", 32'(acc), 32'd100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle_zero("clr");
    repeat (12) tick();
    chk_idle_zero("clr_late_rdy");
    send(2, -3, 1'b1);
    wait_drain("drain_after_clr");

    // Clear together with in_valid in IDLE: pair must not be taken
    in_valid = 1'b1;
    in_a = 8'h11;
    in_b = 8'h22;
    in_last = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("clr_iv_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("clr_iv_start", 32'(mult_start), 32'd0);
    chk("clr_iv_in_ready2", 32'(in_ready), 32'd1);

    // Counter saturation: 256 terms leave cnt at 255
    for (int i = 0; i < 256; i++) send(1, 1, (i == 255));
    wait_drain("drain_sat");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
